// File: rtl/iob_fifo2stream_pkg.sv
// Shared constants and types for the iob_fifo2stream FIFO read-drain engine.
package iob_fifo2stream_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
endpackage

// File: rtl/iob_fifo2stream_buf.sv
// Two-entry output buffer: entry 0 is always the head, pushes land at the tail.
module iob_fifo2stream_buf
  import iob_fifo2stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head,
  output logic [OCC_W-1:0]  o_occ
);
  occ_e              r_occ;
  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic              w_pop;

  assign w_pop   = i_pop & (r_occ != OCC_EMPTY);
  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_head  = r_mem[0];
  assign o_occ   = r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ <= OCC_EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: if (i_push) begin
          r_mem[0] <= i_data;
          r_occ    <= OCC_ONE;
        end
        OCC_ONE: case ({i_push, w_pop})
          2'b10: begin
            r_mem[1] <= i_data;
            r_occ    <= OCC_TWO;
          end
          2'b01:   r_occ <= OCC_EMPTY;
          2'b11:   r_mem[0] <= i_data;
          default: ;
        endcase
        OCC_TWO: if (w_pop) begin
          // head advances; a simultaneous push refills the tail
          r_mem[0] <= r_mem[1];
          if (i_push) r_mem[1] <= i_data;
          else        r_occ    <= OCC_ONE;
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/iob_fifo2stream.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream at full rate.
// Define IOB_FIFO2STREAM_LAST_EN to add a BURST_LEN beat counter driving o_m_last.
module iob_fifo2stream
  import iob_fifo2stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_empty,
  output logic              o_fifo_read_en,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last
);
  logic             r_infl;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ;

  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_burst
    $error("iob_fifo2stream: BURST_LEN out of range 1..65535");
  end

  assign w_pop = o_m_valid & i_m_ready;

  // A slot is free if occupied + in-flight words, minus this cycle's pop, leave room.
  assign o_fifo_read_en = ~i_rst & ~i_fifo_empty &
                          (({1'b0, w_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_infl <= 1'b0;
    else       r_infl <= o_fifo_read_en;
  end

  iob_fifo2stream_buf #(.DATA_W(DATA_W)) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_infl),
    .i_pop   (w_pop),
    .i_data  (i_fifo_data),
    .o_valid (o_m_valid),
    .o_head  (o_m_data),
    .o_occ   (w_occ)
  );

`ifdef IOB_FIFO2STREAM_LAST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] r_cnt;

  assign o_m_last = o_m_valid & (r_cnt == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_cnt <= '0;
    else if (w_pop) r_cnt <= o_m_last ? '0 : r_cnt + 1'b1;
  end
`else
  assign o_m_last = 1'b0;
`endif
endmodule

// File: tb/tb_iob_fifo2stream.sv
// Self-checking bench for iob_fifo2stream: FIFO model plus in-order scoreboard.
module tb_iob_fifo2stream;
  localparam int BL = 4;
`ifdef IOB_FIFO2STREAM_LAST_EN
  localparam bit LAST = 1'b1;
`else
  localparam bit LAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = '0;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  int n_pass = 0;
  int n_chk  = 0;

  // FIFO model: the bench writes at wr_ptr, the read port advances rd_ptr.
  logic [7:0] fmem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_data <= fmem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  iob_fifo2stream #(.DATA_W(8), .BURST_LEN(BL)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_read_en (fifo_rd_en),
    .i_fifo_data    (fifo_data),
    .o_m_valid      (m_valid),
    .i_m_ready      (m_ready),
    .o_m_data       (m_data),
    .o_m_last       (m_last)
  );

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr % 4096] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b0; wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b0; wr_ptr = rd_ptr;
    for (int i = 0; i < 5; i++) push(8'(20 + i));
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b exp 0", fifo_rd_en); else n_pass++;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", m_valid); else n_pass++;
      n_chk++; if (m_data !== 8'd0 || m_last !== 1'b0) $display("FAIL rst_data_last got %h/%b exp 00/0", m_data, m_last); else n_pass++;
      n_chk++; if (dut.u_buf.o_occ !== 2'd0 || dut.r_infl !== 1'b0) $display("FAIL rst_occ_infl got %0d/%b exp 0/0", dut.u_buf.o_occ, dut.r_infl); else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_chk++; if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) $display("FAIL rst_first_strobe got rd=%b v=%b exp 1/0", fifo_rd_en, m_valid); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b1 || m_data !== 8'd20) $display("FAIL rst_first_valid got v=%b d=%h exp 1/14", m_valid, m_data); else n_pass++;
  endtask

  task automatic test_full_rate();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 15; i++) push(8'(i));
    m_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b0) $display("FAIL fr_latency got v=%b exp 0", m_valid); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) $display("FAIL fr_word%0d got v=%b d=%h exp 1/%h", i, m_valid, m_data, 8'(i));
      else n_pass++;
    end
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) $display("FAIL fr_drained got v=%b rd=%b exp 0/0", m_valid, fifo_rd_en); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int strobes = 0;
    int got = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) push(8'(i));
    #1;
    if (fifo_rd_en === 1'b1) strobes++;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) strobes++;
      if (c >= 2) begin
        n_chk++; if (m_valid !== 1'b1 || m_data !== 8'd0) $display("FAIL bp_hold c%0d got v=%b d=%h exp 1/00", c, m_valid, m_data); else n_pass++;
      end
    end
    n_chk++; if (strobes != 2) $display("FAIL bp_strobes got %0d exp 2", strobes); else n_pass++;
    n_chk++; if (dut.u_buf.o_occ !== 2'd2) $display("FAIL bp_occ got %0d exp 2", dut.u_buf.o_occ); else n_pass++;
    m_ready = 1'b1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (c != 0) @(negedge clk);
      if (m_valid === 1'b1) begin
        n_chk++; if (m_data !== 8'(got)) $display("FAIL bp_order got %h exp %h", m_data, 8'(got)); else n_pass++;
        got++;
      end
    end
    n_chk++; if (got != 6) $display("FAIL bp_count got %0d exp 6", got); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] prev_d = '0;
    logic [7:0] v;
    logic prev_stall = 1'b0;
    int sent = 0, got = 0, beat = 0;
    do_reset();
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      n_chk++; if (dut.u_buf.o_occ > 2'd2) $display("FAIL rnd_occ got %0d exp <=2", dut.u_buf.o_occ); else n_pass++;
      if (prev_stall) begin
        n_chk++; if (m_valid !== 1'b1 || m_data !== prev_d) $display("FAIL rnd_stable got v=%b d=%h exp 1/%h", m_valid, m_data, prev_d); else n_pass++;
      end
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        v = 8'($urandom);
        push(v); exp_q.push_back(v); sent++;
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid === 1'b1 && m_ready) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL rnd_extra got %h exp none", m_data);
        else begin
          v = exp_q.pop_front();
          if (m_data !== v) $display("FAIL rnd_data beat %0d got %h exp %h", got, m_data, v); else n_pass++;
        end
        n_chk++; if (m_last !== (LAST && (beat % BL == BL - 1))) $display("FAIL rnd_last beat %0d got %b", beat, m_last); else n_pass++;
        got++; beat++;
      end else if (m_valid !== 1'b1) begin
        n_chk++; if (m_last !== 1'b0) $display("FAIL rnd_last_idle got %b exp 0", m_last); else n_pass++;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_d     = m_data;
    end
    n_chk++; if (got != 1000) $display("FAIL rnd_count got %0d exp 1000", got); else n_pass++;
  endtask

  task automatic test_last();
    logic [15:0] mask = '0;
    logic [15:0] exp_mask;
    int got = 0;
    exp_mask = LAST ? 16'h0888 : 16'h0000;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 12; i++) push(8'(50 + i));
    for (int c = 0; c < 200 && got < 12; c++) begin
      if (c != 0) @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid === 1'b1 && m_ready) begin
        n_chk++; if (m_data !== 8'(50 + got)) $display("FAIL last_data got %h exp %h", m_data, 8'(50 + got)); else n_pass++;
        if (m_last === 1'b1) mask[got] = 1'b1;
        got++;
      end
    end
    n_chk++; if (mask !== exp_mask) $display("FAIL last_mask got %h exp %h", mask, exp_mask); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] mask = '0;
    logic [15:0] exp_mask;
    int got = 0;
    exp_mask = LAST ? 16'h0088 : 16'h0000;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(8'(i));
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (dut.r_infl !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'd2) $display("FAIL mr_pre got infl=%b v=%b d=%h exp 1/1/02", dut.r_infl, m_valid, m_data); else n_pass++;
    rst = 1'b1; wr_ptr = rd_ptr;
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) $display("FAIL mr_after got v=%b l=%b rd=%b exp 0/0/0", m_valid, m_last, fifo_rd_en); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(100 + i));
    for (int c = 0; c < 50 && got < 8; c++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        n_chk++; if (m_data !== 8'(100 + got)) $display("FAIL mr_data got %h exp %h", m_data, 8'(100 + got)); else n_pass++;
        if (m_last === 1'b1) mask[got] = 1'b1;
        got++;
      end
    end
    n_chk++; if (mask !== exp_mask || got != 8) $display("FAIL mr_mask got %h/%0d exp %h/8", mask, got, exp_mask); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random();
    test_last();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
